// File: rtl/instr_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words from a
// valid/ready byte link and writes them to instruction memory while holding the CPU.
module instr_loader #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] word_count_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic             busy_o,
  output logic             cpu_hold_o,
  output logic             done_o,
  output logic             error_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [23:0]        asm_q, asm_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept;

  // Ready is a registered copy of "state is RECV", so acceptance never
  // depends combinationally on byte_valid_i.
  assign accept = byte_valid_i & ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (word_count_i == '0) begin
            err_d   = 1'b0;
            state_d = DONE;
          end else if (word_count_i > CNT_W'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            cnt_d   = word_count_i;
            err_d   = 1'b0;
            idx_d   = '0;
            bcnt_d  = '0;
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (accept) begin
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: asm_d[7:0]   = byte_data_i;
            2'd1: asm_d[15:8]  = byte_data_i;
            2'd2: asm_d[23:16] = byte_data_i;
            default: begin
              // Last byte goes straight into the write register.
              wdata_d = {byte_data_i, asm_q};
              addr_d  = 32'({idx_q, 2'b00});
              state_d = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        if (CNT_W'(idx_q) + CNT_W'(1) == cnt_q) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          bcnt_d  = '0;
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == RECV);
    we_d    = (state_d == WRITE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  assign byte_ready_o = ready_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = busy_q;
  assign cpu_hold_o   = busy_q;
  assign done_o       = done_q;
  assign error_o      = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed, table-driven bench for instr_loader: loads, error/zero-count
// starts, mid-load reset and a full-depth image.
module tb_instr_loader;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned CNT_W = 7;

  logic             clk_i;
  logic             rst_i;
  logic             start_i;
  logic [CNT_W-1:0] word_count_i;
  logic             byte_valid_i;
  logic [7:0]       byte_data_i;
  logic             byte_ready_o;
  logic             mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic             busy_o;
  logic             cpu_hold_o;
  logic             done_o;
  logic             error_o;

  instr_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .word_count_i (word_count_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .busy_o       (busy_o),
    .cpu_hold_o   (cpu_hold_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [CNT_W-1:0] wc;
    bit               gap;
    logic [63:0]      bytes;
    int               nw;
    logic [31:0]      w0;
    logic [31:0]      w1;
    logic             err;
  } vec_t;

  vec_t        vecs[7];
  logic [7:0]  stim_bytes[256];
  logic [63:0] wlog[$];
  int          done_cnt;
  int          n_checks;
  int          n_pass;
  int          mid_start_at;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Write log and done counter, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (mem_we_o) begin
      wlog.push_back({mem_addr_o, mem_wdata_o});
      chk("ready_low_in_write", 32'(byte_ready_o), 32'd0);
      chk("hold_in_write", 32'(cpu_hold_o), 32'd1);
    end
  end

  task automatic feed_byte(input logic [7:0] b, input bit gap);
    int budget;
    budget = 40;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    while (!byte_ready_o && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) chk("ready_timeout", 32'd0, 32'd1);
    step();
    if (gap) begin
      byte_valid_i = 1'b0;
      step();
    end
  endtask

  task automatic run_load(input logic [CNT_W-1:0] wc, input bit gap);
    int budget;
    wlog.delete();
    done_cnt     = 0;
    start_i      = 1'b1;
    word_count_i = wc;
    step();
    start_i = 1'b0;
    if (32'(wc) > DEPTH) begin
      chk("ovf_busy", 32'(busy_o), 32'd0);
      chk("ovf_ready", 32'(byte_ready_o), 32'd0);
      repeat (3) step();
      chk("ovf_no_done", 32'(done_cnt), 32'd0);
    end else if (wc == '0) begin
      chk("zc_done", 32'(done_o), 32'd1);
      chk("zc_hold", 32'(cpu_hold_o), 32'd1);
      step();
      chk("zc_idle", 32'(busy_o), 32'd0);
      chk("zc_done_once", 32'(done_cnt), 32'd1);
    end else begin
      chk("hold_after_start", 32'(cpu_hold_o), 32'd1);
      for (int k = 0; k < 4 * int'(wc); k++) begin
        if (k == mid_start_at) begin
          start_i      = 1'b1;
          word_count_i = CNT_W'(1);
        end
        feed_byte(stim_bytes[k], gap);
        start_i = 1'b0;
      end
      byte_valid_i = 1'b0;
      budget = 20;
      while (!done_o && budget > 0) begin
        chk("hold_until_done", 32'(cpu_hold_o), 32'd1);
        step();
        budget--;
      end
      chk("done_seen", 32'(done_o), 32'd1);
      chk("hold_in_done", 32'(cpu_hold_o), 32'd1);
      step();
      chk("hold_drop", 32'(cpu_hold_o), 32'd0);
      chk("done_once", 32'(done_cnt), 32'd1);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, 32'(byte_ready_o), 32'd0);
    chk({nm, "_we"},    32'(mem_we_o),     32'd0);
    chk({nm, "_addr"},  mem_addr_o,        32'd0);
    chk({nm, "_wdata"}, mem_wdata_o,       32'd0);
    chk({nm, "_busy"},  32'(busy_o),       32'd0);
    chk({nm, "_hold"},  32'(cpu_hold_o),   32'd0);
    chk({nm, "_done"},  32'(done_o),       32'd0);
    chk({nm, "_error"}, 32'(error_o),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ent;
    logic [31:0] expw;
    n_checks = 0;
    n_pass   = 0;
    done_cnt = 0;
    mid_start_at = -1;

    vecs[0] = '{wc: 7'd2,  gap: 1'b0, bytes: 64'hDEADBEEF_12345678, nw: 2, w0: 32'h12345678, w1: 32'hDEADBEEF, err: 1'b0};
    vecs[1] = '{wc: 7'd2,  gap: 1'b1, bytes: 64'hDEADBEEF_12345678, nw: 2, w0: 32'h12345678, w1: 32'hDEADBEEF, err: 1'b0};
    vecs[2] = '{wc: 7'd65, gap: 1'b0, bytes: 64'h0,                 nw: 0, w0: 32'h0,        w1: 32'h0,        err: 1'b1};
    vecs[3] = '{wc: 7'd0,  gap: 1'b0, bytes: 64'h0,                 nw: 0, w0: 32'h0,        w1: 32'h0,        err: 1'b0};
    vecs[4] = '{wc: 7'd65, gap: 1'b0, bytes: 64'h0,                 nw: 0, w0: 32'h0,        w1: 32'h0,        err: 1'b1};
    vecs[5] = '{wc: 7'd1,  gap: 1'b0, bytes: 64'h00000000_0BADCAFE, nw: 1, w0: 32'h0BADCAFE, w1: 32'h0,        err: 1'b0};
    vecs[6] = '{wc: 7'd1,  gap: 1'b1, bytes: 64'h00000000_04030201, nw: 1, w0: 32'h04030201, w1: 32'h0,        err: 1'b0};

    rst_i = 1'b1; start_i = 1'b0; word_count_i = '0;
    byte_valid_i = 1'b0; byte_data_i = '0;
    repeat (2) step();
    chk_all_zero("reset");
    rst_i = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 8; k++) stim_bytes[k] = vecs[i].bytes[8*k +: 8];
      run_load(vecs[i].wc, vecs[i].gap);
      chk($sformatf("v%0d_err", i), 32'(error_o), 32'(vecs[i].err));
      chk($sformatf("v%0d_nwr", i), 32'(wlog.size()), 32'(vecs[i].nw));
      if (vecs[i].nw >= 1 && wlog.size() >= 1) begin
        ent = wlog[0];
        chk($sformatf("v%0d_addr0", i), ent[63:32], 32'h0);
        chk($sformatf("v%0d_data0", i), ent[31:0], vecs[i].w0);
      end
      if (vecs[i].nw >= 2 && wlog.size() >= 2) begin
        ent = wlog[1];
        chk($sformatf("v%0d_addr1", i), ent[63:32], 32'h4);
        chk($sformatf("v%0d_data1", i), ent[31:0], vecs[i].w1);
      end
      step();
    end

    // Reset after two bytes of the second word of a 4-word load.
    for (int k = 0; k < 16; k++) stim_bytes[k] = 8'(k + 16);
    start_i = 1'b1; word_count_i = 7'd4;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 6; k++) feed_byte(stim_bytes[k], 1'b0);
    byte_valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    chk_all_zero("midrst");
    rst_i = 1'b0;
    step();
    stim_bytes[0] = 8'h44; stim_bytes[1] = 8'h33;
    stim_bytes[2] = 8'h22; stim_bytes[3] = 8'h11;
    run_load(7'd1, 1'b0);
    chk("post_rst_nwr", 32'(wlog.size()), 32'd1);
    if (wlog.size() >= 1) begin
      ent = wlog[0];
      chk("post_rst_addr", ent[63:32], 32'h0);
      chk("post_rst_data", ent[31:0], 32'h11223344);
    end
    step();

    // Full-depth image with a stray start pulse in the middle.
    for (int k = 0; k < 256; k++) stim_bytes[k] = 8'(k * 37 + 11);
    mid_start_at = 100;
    run_load(7'd64, 1'b0);
    mid_start_at = -1;
    chk("full_err", 32'(error_o), 32'd0);
    chk("full_nwr", 32'(wlog.size()), 32'd64);
    for (int w = 0; w < 64 && w < wlog.size(); w++) begin
      ent  = wlog[w];
      expw = {stim_bytes[4*w+3], stim_bytes[4*w+2], stim_bytes[4*w+1], stim_bytes[4*w]};
      chk($sformatf("full_addr%0d", w), ent[63:32], 32'(4 * w));
      chk($sformatf("full_data%0d", w), ent[31:0], expw);
    end
    if (wlog.size() >= 1) begin
      ent = wlog[wlog.size() - 1];
      chk("full_last_addr", ent[63:32], 32'h000000FC);
    end
    repeat (3) step();
    chk("full_idle", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
